// File: rtl/serial_deserializer.sv
// Serial-to-parallel word assembler with a single-entry valid/ready output slot
// and a sticky flag for completed words dropped while the slot was still full.
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     ser_in,
  input  logic                     ser_en,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overflow
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

  slot_t            state;
  slot_t            state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] out_data_next;
  logic [CW-1:0]    bit_cnt_next;
  logic             overflow_next;
  logic             complete;

  // Shift register and bit counter; completion includes the bit sampled now.
  always_comb begin
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    complete     = 1'b0;
    if (ser_en) begin
      if (MSB_FIRST) begin
        shreg_next = {shreg[WIDTH-2:0], ser_in};
      end else begin
        shreg_next = {ser_in, shreg[WIDTH-1:1]};
      end
      if (bit_cnt == LAST) begin
        bit_cnt_next = '0;
        complete     = 1'b1;
      end else begin
        bit_cnt_next = bit_cnt + ONE;
      end
    end else begin
      shreg_next   = shreg;
      bit_cnt_next = bit_cnt;
    end
  end

  // Output slot: a full slot refills without a bubble when the consumer takes it.
  always_comb begin
    state_next    = state;
    out_data_next = out_data;
    overflow_next = overflow;
    case (state)
      EMPTY: begin
        if (complete) begin
          state_next    = FULL;
          out_data_next = shreg_next;
        end else begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (complete) begin
            out_data_next = shreg_next;
          end else begin
            state_next = EMPTY;
          end
        end else begin
          if (complete) begin
            overflow_next = 1'b1;
          end else begin
            state_next = FULL;
          end
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // State registers with async reset and synchronous clear of identical values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      shreg    <= '0;
      bit_cnt  <= '0;
      out_data <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      state    <= EMPTY;
      shreg    <= '0;
      bit_cnt  <= '0;
      out_data <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      shreg    <= shreg_next;
      bit_cnt  <= bit_cnt_next;
      out_data <= out_data_next;
      overflow <= overflow_next;
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_serial_deserializer.sv
// Randomized and directed bench for serial_deserializer; MSB-first and LSB-first
// instances share stimulus and are checked against an arrival-order bit model.
module tb_serial_deserializer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         ser_in;
  logic         ser_en;
  logic         out_ready;
  logic [W-1:0] data_m, data_l;
  logic         valid_m, valid_l;
  logic [2:0]   cnt_m, cnt_l;
  logic         ovf_m, ovf_l;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: bits of the current word by arrival order, plus the output slot.
  bit           m_bits [W];
  int           m_cnt;
  bit           m_valid;
  bit           m_ovf;
  logic [W-1:0] m_dm, m_dl;

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .clr(clr), .ser_in(ser_in), .ser_en(ser_en),
    .out_ready(out_ready), .out_data(data_m), .out_valid(valid_m),
    .bit_cnt(cnt_m), .overflow(ovf_m)
  );

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .clr(clr), .ser_in(ser_in), .ser_en(ser_en),
    .out_ready(out_ready), .out_data(data_l), .out_valid(valid_l),
    .bit_cnt(cnt_l), .overflow(ovf_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) m_bits[i] = 1'b0;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_dm    = '0;
    m_dl    = '0;
  endtask

  task automatic model_update();
    bit           done;
    logic [W-1:0] wm, wl;
    if (clr) begin
      model_reset();
    end else begin
      done = ser_en && (m_cnt == W - 1);
      if (ser_en) m_bits[m_cnt] = ser_in;
      for (int i = 0; i < W; i++) begin
        wm[W-1-i] = m_bits[i];
        wl[i]     = m_bits[i];
      end
      if (!m_valid) begin
        if (done) begin
          m_valid = 1'b1;
          m_dm    = wm;
          m_dl    = wl;
        end
      end else if (out_ready) begin
        if (done) begin
          m_dm = wm;
          m_dl = wl;
        end else begin
          m_valid = 1'b0;
        end
      end else if (done) begin
        m_ovf = 1'b1;
      end
      if (ser_en) m_cnt = (m_cnt + 1) % W;
    end
  endtask

  task automatic compare_all();
    check_eq("valid_m", 32'(valid_m), 32'(m_valid));
    check_eq("valid_l", 32'(valid_l), 32'(m_valid));
    check_eq("data_m",  32'(data_m),  32'(m_dm));
    check_eq("data_l",  32'(data_l),  32'(m_dl));
    check_eq("cnt_m",   32'(cnt_m),   32'(m_cnt));
    check_eq("cnt_l",   32'(cnt_l),   32'(m_cnt));
    check_eq("ovf_m",   32'(ovf_m),   32'(m_ovf));
    check_eq("ovf_l",   32'(ovf_l),   32'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic b, input logic en, input logic rdy, input logic c);
    ser_in    = b;
    ser_en    = en;
    out_ready = rdy;
    clr       = c;
    step();
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy);
    for (int i = 0; i < W; i++) drive(w[W-1-i], 1'b1, rdy, 1'b0);
  endtask

  initial begin
    logic [W-1:0] pat;
    rst = 1'b0; clr = 1'b0; ser_in = 1'b0; ser_en = 1'b0; out_ready = 1'b0;
    model_reset();
    #3;
    check_eq("rst_valid", 32'(valid_m), 32'd0);
    check_eq("rst_data",  32'(data_m),  32'd0);
    check_eq("rst_cnt",   32'(cnt_m),   32'd0);
    check_eq("rst_ovf",   32'(ovf_m),   32'd0);
    #4 rst = 1'b1;

    // Bits 1,0,1,1,0,0,1,0 with the consumer always ready.
    pat = 8'hB2;
    send_word(pat, 1'b1);
    check_eq("b2_valid", 32'(valid_m), 32'd1);
    check_eq("b2_msb",   32'(data_m),  32'hB2);
    check_eq("b2_lsb",   32'(data_l),  32'h4D);
    check_eq("b2_cnt",   32'(cnt_m),   32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("b2_valid_1cyc", 32'(valid_m), 32'd0);

    // Two words with no consumer: the second is dropped and flagged.
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b0);
    check_eq("ovf_data",  32'(data_m),  32'hA5);
    check_eq("ovf_flag",  32'(ovf_m),   32'd1);
    check_eq("ovf_valid", 32'(valid_m), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("ovf_drain_valid", 32'(valid_m), 32'd0);
    check_eq("ovf_sticky",      32'(ovf_m),   32'd1);

    // Clear in the middle of a word discards the partial bits.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("clr_cnt",   32'(cnt_m),   32'd0);
    check_eq("clr_ovf",   32'(ovf_m),   32'd0);
    check_eq("clr_valid", 32'(valid_m), 32'd0);
    send_word(8'h81, 1'b0);
    check_eq("clr_next_word", 32'(data_m), 32'h81);

    // ser_en toggling: 8 enabled bits complete on the 15th cycle.
    pat = 8'hF0;
    for (int i = 0; i < 15; i++) begin
      drive(pat[W-1-(i/2)], (i % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      if (i == 13) check_eq("tog_not_yet", 32'(valid_m), 32'd0);
    end
    check_eq("tog_valid", 32'(valid_m), 32'd1);
    check_eq("tog_data",  32'(data_m),  32'hF0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
    end

    // Fill the slot, then reset asynchronously between clock edges.
    send_word(8'h5A, 1'b0);
    check_eq("pre_rst_valid", 32'(valid_m), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("async_valid", 32'(valid_m), 32'd0);
    check_eq("async_data",  32'(data_m),  32'd0);
    check_eq("async_ovf",   32'(ovf_m),   32'd0);
    check_eq("async_cnt",   32'(cnt_m),   32'd0);
    model_reset();
    #2 rst = 1'b1;
    send_word(8'h69, 1'b1);
    check_eq("post_rst_data", 32'(data_m), 32'h69);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
